// File: rtl/mem_bus_master.sv
// mem_bus_master
//   CPU-side initiator for the byte-serial memory bus (the counterpart of
//   memory_top). It turns one RISC-V load/store request into one bus
//   transaction. Store data is left-justified, and load data is masked and
//   extended. A watchdog plus a drain state keep at most one transaction
//   outstanding.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_req, i_we        request strobe (sampled while o_ready) and store flag
//   i_funct3           RISC-V load/store funct3
//   i_addr, i_wdata    byte address, right-justified store data
//   o_ready            high only in IDLE
//   o_done, o_err      completion pulse; o_err marks illegal funct3 / timeout
//   o_rdata            extended load result, held until the next o_done
//   o_bus_*            request side towards memory_top
//   o_bhw              byte count 001/010/100
//   o_write_notread    1 = bus write
//   i_bus_data/DV      response from memory_top
module mem_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic             legal;
    logic [2:0]       bhw_enc;
    logic [31:0]      wdata_lj;
    logic [31:0]      rdata_ext;

    // Loads allow B/H/W/BU/HU, stores only B/H/W.
    always_comb begin
        legal = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~i_we;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        bhw_enc = 3'b100;
        case (i_funct3[1:0])
            2'b00:   bhw_enc = 3'b001;
            2'b01:   bhw_enc = 3'b010;
            default: bhw_enc = 3'b100;
        endcase
    end

    // The responder consumes the top bytes on short writes.
    always_comb begin
        wdata_lj = '0;
        if (i_we) begin
            case (i_funct3[1:0])
                2'b00:   wdata_lj = {i_wdata[7:0], 24'h0};
                2'b01:   wdata_lj = {i_wdata[15:0], 16'h0};
                default: wdata_lj = i_wdata;
            endcase
        end
    end

    // Only the low bytes of the response are meaningful; upper bytes are stale.
    always_comb begin
        rdata_ext = i_bus_data;
        case (f3_q)
            3'b000:  rdata_ext = {{24{i_bus_data[7]}}, i_bus_data[7:0]};
            3'b100:  rdata_ext = {24'h0, i_bus_data[7:0]};
            3'b001:  rdata_ext = {{16{i_bus_data[15]}}, i_bus_data[15:0]};
            3'b101:  rdata_ext = {16'h0, i_bus_data[15:0]};
            default: rdata_ext = i_bus_data;
        endcase
    end

    assign o_ready  = (state == S_IDLE);
    assign o_bus_DV = (state == S_ISSUE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            f3_q            <= '0;
            o_done          <= 1'b0;
            o_err           <= 1'b0;
            o_rdata         <= '0;
            o_bus_data      <= '0;
            o_bus_address   <= '0;
            o_bhw           <= '0;
            o_write_notread <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        if (legal) begin
                            f3_q            <= i_funct3;
                            o_bus_address   <= i_addr;
                            o_bus_data      <= wdata_lj;
                            o_bhw           <= bhw_enc;
                            o_write_notread <= i_we;
                            state           <= S_ISSUE;
                        end else begin
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response on the timeout cycle still counts as success.
                    if (i_bus_DV) begin
                        o_done <= 1'b1;
                        if (!o_write_notread) begin
                            o_rdata <= rdata_ext;
                        end
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        o_done <= 1'b1;
                        o_err  <= 1'b1;
                        state  <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Responder may still be busy; swallow its late pulse.
                    if (i_bus_DV) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
Bus initiator that drives the byte-serial memory bus from the CPU side, the counterpart of memory_top. It converts a RISC-V load/store request (funct3, address, store data) into one bus transaction. It encodes the byte count, left-justifies store data and issues a one-cycle request strobe. It then waits for the response strobe, masks the returned data and sign- or zero-extends it to 32 bits. A timeout watchdog and a drain state guarantee that at most one transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 4096, cycles spent in WAIT before the transaction is aborted with o_err; legal range 2..65535
CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_req  in  1  CPU request strobe; sampled only when o_ready=1
i_we  in  1  1=store, 0=load
i_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_addr  in  32  byte address; misaligned addresses allowed
i_wdata  in  32  store data, right-justified
o_ready  out  1  high only in IDLE
o_done  out  1  one-cycle completion pulse
o_err  out  1  qualifies o_done: illegal funct3 or timeout
o_rdata  out  32  extended load result; valid with o_done, held until next o_done
o_bus_data  out  32  to memory_top i_bus_data
o_bus_address  out  32  to memory_top i_bus_address
o_bus_DV  out  1  to memory_top i_bus_DV
o_bhw  out  3  to memory_top i_bhw: byte count (001/010/100)
o_write_notread  out  1  to memory_top i_write_notread
i_bus_data  in  32  from memory_top o_bus_data
i_bus_DV  in  1  from memory_top o_bus_DV (one-cycle pulse)

Behaviour:
- Single clock domain. Reset is synchronous and active-low on i_rst_n; i_clk is the only clock.
- On reset, within one edge:
  - state=IDLE; o_ready=1.
  - o_done, o_err, o_bus_DV, o_write_notread all 0.
  - o_bhw=000; o_rdata, o_bus_data, o_bus_address all 0; counter=0.
- Reset mid-transaction returns the block to IDLE. A responder pulse that arrives later while in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE, i_req=1:
  - Decode i_funct3 against i_we.
  - Legal: latch request, drive the bus registers, go to ISSUE.
  - Illegal (load 011/110/111; store 011..111): o_done=1 and o_err=1 next cycle, o_rdata unchanged, no bus strobe, stay IDLE.
- Bus encoding:
  - o_bhw: funct3[1:0]=00 gives 001, 01 gives 010, 10 gives 100.
  - o_bus_address=i_addr.
  - o_write_notread=i_we.
  - Store data is left-justified, because the responder consumes the top bytes for short writes.
  - SB: o_bus_data={i_wdata[7:0],24'h0}. SH: {i_wdata[15:0],16'h0}. SW: i_wdata.
  - For loads, o_bus_data=0.
- ISSUE: o_bus_DV=1 for exactly one cycle; counter cleared; go to WAIT. Bus address, data, bhw and write are held stable until the next IDLE accept.
- WAIT:
  - Counter increments each cycle.
  - i_bus_DV=1: go to IDLE; o_done=1 the next cycle.
  - For loads, o_rdata is extended from the low bytes:
    - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
    - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
    - LW: full word.
  - Upper returned bytes are stale and must be discarded.
  - For stores, o_rdata is unchanged.
  - Counter reaches TIMEOUT_CYCLES-1 without i_bus_DV: o_done=1 and o_err=1 next cycle; go to DRAIN.
  - i_bus_DV arriving on the timeout cycle counts as success.
- DRAIN: o_ready=0; wait for the late i_bus_DV, discard it, go to IDLE. No new bus strobe while the responder may still be busy.
- Latency: i_req accepted at edge 0, o_bus_DV high in cycle 1. o_done is high in the cycle after the edge that samples i_bus_DV.
- Back-to-back requests: o_ready=1 in the o_done cycle, so a new i_req can be accepted there.
- o_bus_DV is never asserted outside ISSUE; o_bhw is never driven to 000.

Test Plan:
- LW addr 0x100, responder returns 0xDEADBEEF -> o_bhw=100, o_write_notread=0, one o_bus_DV pulse, o_rdata=0xDEADBEEF, o_err=0.
- LB and LBU addr 0x203, i_bus_data=0x123456F0 -> LB o_rdata=0xFFFFFFF0; LBU o_rdata=0x000000F0.
- LH and LHU, i_bus_data=0xAAAA8001 -> LH 0xFFFF8001; LHU 0x00008001.
- SB i_wdata=0x000000A5, SH i_wdata=0x0000BEEF, SW 0x01020304 -> o_bus_data 0xA5000000/bhw 001, 0xBEEF0000/bhw 010, 0x01020304/bhw 100; o_rdata unchanged.
- Store with funct3=011 -> o_done=o_err=1 one cycle later, no o_bus_DV; load with funct3=110 -> same response.
- Timeout and reset:
  - TIMEOUT_CYCLES=8, responder silent -> o_err with o_done after 8 WAIT cycles, then DRAIN, o_ready=0.
  - Late i_bus_DV -> back to IDLE, o_rdata unchanged.
  - Separately, i_rst_n=0 during WAIT -> IDLE; the late response is ignored and o_done stays 0.
